// File: rtl/axi_grid_xni_pkg.sv
// Shared types and sizing helpers for the buffered grid cross-node interface.
// Default element field types stand in for the project-wide AXI grid types.
package axi_grid_xni_pkg;

    typedef enum logic [2:0] {
        AW = 3'd0,
        W  = 3'd1,
        B  = 3'd2,
        AR = 3'd3,
        R  = 3'd4
    } chan_e;

    localparam int NUM_CHAN = 5;

    typedef logic [3:0]  id_def_t;
    typedef logic [15:0] aw_def_t;
    typedef logic [15:0] w_def_t;
    typedef logic [3:0]  b_def_t;
    typedef logic [15:0] ar_def_t;
    typedef logic [15:0] r_def_t;

    function automatic int occ_w(int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int max_i(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_grid_xni_if.sv
// One grid channel link: routing IDs, payload and valid/ready handshake.
// master drives the element, slave returns ready.
interface axi_grid_xni_if #(
    parameter type id_t   = logic [3:0],
    parameter type chan_t = logic [15:0]
);
    id_t   did;
    id_t   sid;
    chan_t chan;
    logic  valid;
    logic  ready;

    modport master (output did, sid, chan, valid, input ready);
    modport slave  (input did, sid, chan, valid, output ready);
endinterface

// File: rtl/axi_grid_xni_fifo.sv
// Elastic FIFO with occupancy, sticky high-water mark and synchronous flush.
// DEPTH=0 degenerates to a plain wire.
module axi_grid_xni_fifo
    import axi_grid_xni_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int OCC_W      = occ_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [ELEM_WIDTH-1:0] elem_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ELEM_WIDTH-1:0] elem_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OCC_W-1:0]      occ_o,
    output logic [OCC_W-1:0]      hwm_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused  = ^{clk_i, rst_ni, flush_i};
        assign elem_o  = elem_i;
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign occ_o   = '0;
        assign hwm_o   = '0;
    end else begin : g_buf
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PW-1:0]    LAST = PW'(DEPTH - 1);
        localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

        logic [ELEM_WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
        logic [OCC_W-1:0]      occ_q, occ_d, hwm_q, hwm_d;
        logic                  rdy_q, rdy_d;
        logic                  push, pop;

        // ready is registered; flush only masks it, never ready_i
        assign ready_o = rdy_q & ~flush_i;
        assign valid_o = (occ_q != '0);
        assign elem_o  = mem_q[rd_q];
        assign occ_o   = occ_q;
        assign hwm_o   = hwm_q;
        assign push    = valid_i & ready_o;
        assign pop     = valid_o & ready_i;

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            occ_d = occ_q;
            hwm_d = hwm_q;
            rdy_d = rdy_q;
            if (flush_i) begin
                wr_d  = '0;
                rd_d  = '0;
                occ_d = '0;
                hwm_d = '0;
                rdy_d = 1'b1;
            end else begin
                if (push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
                if (pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
                occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
                if (occ_d > hwm_q) hwm_d = occ_d;
                rdy_d = (occ_d < FULL);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wr_q  <= '0;
                rd_q  <= '0;
                occ_q <= '0;
                hwm_q <= '0;
                rdy_q <= 1'b0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                occ_q <= occ_d;
                hwm_q <= hwm_d;
                rdy_q <= rdy_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_q] <= elem_i;
        end
    end

endmodule

// File: rtl/axi_grid_xni_buf.sv
// Buffered grid cross-node interface: one elastic FIFO per AXI grid channel.
// Element = {did, sid, chan}, stored and released atomically.
module axi_grid_xni_buf
    import axi_grid_xni_pkg::*;
#(
    parameter type grid_id_t      = id_def_t,
    parameter type grid_aw_chan_t = aw_def_t,
    parameter type grid_w_chan_t  = w_def_t,
    parameter type grid_b_chan_t  = b_def_t,
    parameter type grid_ar_chan_t = ar_def_t,
    parameter type grid_r_chan_t  = r_def_t,
    parameter grid_id_t NI_ID     = '0,
    parameter int AW_DEPTH        = 2,
    parameter int W_DEPTH         = 2,
    parameter int B_DEPTH         = 2,
    parameter int AR_DEPTH        = 2,
    parameter int R_DEPTH         = 2,
    localparam int OCC_W = occ_w(max_i(max_i(max_i(AW_DEPTH, W_DEPTH),
                                             max_i(B_DEPTH, AR_DEPTH)), R_DEPTH))
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    axi_grid_xni_if.slave      aw_s,
    axi_grid_xni_if.master     aw_m,
    axi_grid_xni_if.slave      w_s,
    axi_grid_xni_if.master     w_m,
    axi_grid_xni_if.slave      b_s,
    axi_grid_xni_if.master     b_m,
    axi_grid_xni_if.slave      ar_s,
    axi_grid_xni_if.master     ar_m,
    axi_grid_xni_if.slave      r_s,
    axi_grid_xni_if.master     r_m,
    output logic [OCC_W-1:0]   aw_occ_o,
    output logic [OCC_W-1:0]   aw_hwm_o,
    output logic [OCC_W-1:0]   w_occ_o,
    output logic [OCC_W-1:0]   w_hwm_o,
    output logic [OCC_W-1:0]   b_occ_o,
    output logic [OCC_W-1:0]   b_hwm_o,
    output logic [OCC_W-1:0]   ar_occ_o,
    output logic [OCC_W-1:0]   ar_hwm_o,
    output logic [OCC_W-1:0]   r_occ_o,
    output logic [OCC_W-1:0]   r_hwm_o
);

    localparam int IW    = 2 * $bits(grid_id_t);
    localparam int AW_EW = IW + $bits(grid_aw_chan_t);
    localparam int W_EW  = IW + $bits(grid_w_chan_t);
    localparam int B_EW  = IW + $bits(grid_b_chan_t);
    localparam int AR_EW = IW + $bits(grid_ar_chan_t);
    localparam int R_EW  = IW + $bits(grid_r_chan_t);

    // node ID is informational only
    grid_id_t ni_unused;
    assign ni_unused = NI_ID;

    logic [AW_EW-1:0] aw_ei, aw_eo;
    logic [W_EW-1:0]  w_ei,  w_eo;
    logic [B_EW-1:0]  b_ei,  b_eo;
    logic [AR_EW-1:0] ar_ei, ar_eo;
    logic [R_EW-1:0]  r_ei,  r_eo;

    assign aw_ei = {aw_s.did, aw_s.sid, aw_s.chan};
    assign w_ei  = {w_s.did,  w_s.sid,  w_s.chan};
    assign b_ei  = {b_s.did,  b_s.sid,  b_s.chan};
    assign ar_ei = {ar_s.did, ar_s.sid, ar_s.chan};
    assign r_ei  = {r_s.did,  r_s.sid,  r_s.chan};

    assign {aw_m.did, aw_m.sid, aw_m.chan} = aw_eo;
    assign {w_m.did,  w_m.sid,  w_m.chan}  = w_eo;
    assign {b_m.did,  b_m.sid,  b_m.chan}  = b_eo;
    assign {ar_m.did, ar_m.sid, ar_m.chan} = ar_eo;
    assign {r_m.did,  r_m.sid,  r_m.chan}  = r_eo;

    axi_grid_xni_fifo #(.ELEM_WIDTH(AW_EW), .DEPTH(AW_DEPTH), .OCC_W(OCC_W)) u_aw (
        .clk_i, .rst_ni, .flush_i,
        .elem_i(aw_ei), .valid_i(aw_s.valid), .ready_o(aw_s.ready),
        .elem_o(aw_eo), .valid_o(aw_m.valid), .ready_i(aw_m.ready),
        .occ_o(aw_occ_o), .hwm_o(aw_hwm_o));

    axi_grid_xni_fifo #(.ELEM_WIDTH(W_EW), .DEPTH(W_DEPTH), .OCC_W(OCC_W)) u_w (
        .clk_i, .rst_ni, .flush_i,
        .elem_i(w_ei), .valid_i(w_s.valid), .ready_o(w_s.ready),
        .elem_o(w_eo), .valid_o(w_m.valid), .ready_i(w_m.ready),
        .occ_o(w_occ_o), .hwm_o(w_hwm_o));

    axi_grid_xni_fifo #(.ELEM_WIDTH(B_EW), .DEPTH(B_DEPTH), .OCC_W(OCC_W)) u_b (
        .clk_i, .rst_ni, .flush_i,
        .elem_i(b_ei), .valid_i(b_s.valid), .ready_o(b_s.ready),
        .elem_o(b_eo), .valid_o(b_m.valid), .ready_i(b_m.ready),
        .occ_o(b_occ_o), .hwm_o(b_hwm_o));

    axi_grid_xni_fifo #(.ELEM_WIDTH(AR_EW), .DEPTH(AR_DEPTH), .OCC_W(OCC_W)) u_ar (
        .clk_i, .rst_ni, .flush_i,
        .elem_i(ar_ei), .valid_i(ar_s.valid), .ready_o(ar_s.ready),
        .elem_o(ar_eo), .valid_o(ar_m.valid), .ready_i(ar_m.ready),
        .occ_o(ar_occ_o), .hwm_o(ar_hwm_o));

    axi_grid_xni_fifo #(.ELEM_WIDTH(R_EW), .DEPTH(R_DEPTH), .OCC_W(OCC_W)) u_r (
        .clk_i, .rst_ni, .flush_i,
        .elem_i(r_ei), .valid_i(r_s.valid), .ready_o(r_s.ready),
        .elem_o(r_eo), .valid_o(r_m.valid), .ready_i(r_m.ready),
        .occ_o(r_occ_o), .hwm_o(r_hwm_o));

endmodule

// File: tb/tb_axi_grid_xni_buf.sv
// Scoreboard bench for axi_grid_xni_buf with AW=4, W=2, B=1, AR=0, R=3.
// Channel index order: 0=aw 1=w 2=b 3=ar 4=r.
module tb_axi_grid_xni_buf;
    import axi_grid_xni_pkg::*;

    localparam int DEP [NUM_CHAN] = '{4, 2, 1, 0, 3};
    localparam int N_RND = 4000;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    always #5 clk_i = ~clk_i;

    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(aw_def_t)) aw_s ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(aw_def_t)) aw_m ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(w_def_t))  w_s ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(w_def_t))  w_m ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(b_def_t))  b_s ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(b_def_t))  b_m ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(ar_def_t)) ar_s ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(ar_def_t)) ar_m ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(r_def_t))  r_s ();
    axi_grid_xni_if #(.id_t(id_def_t), .chan_t(r_def_t))  r_m ();

    logic [31:0] de  [NUM_CHAN];
    logic        dv  [NUM_CHAN];
    logic        dr  [NUM_CHAN];
    logic [31:0] ie  [NUM_CHAN];
    logic [31:0] oe  [NUM_CHAN];
    logic        iv  [NUM_CHAN];
    logic        ir  [NUM_CHAN];
    logic        ov  [NUM_CHAN];
    logic        orr [NUM_CHAN];
    logic [2:0]  occ [NUM_CHAN];
    logic [2:0]  hwm [NUM_CHAN];

    assign {aw_s.did, aw_s.sid, aw_s.chan} = de[0][23:0];
    assign {w_s.did,  w_s.sid,  w_s.chan}  = de[1][23:0];
    assign {b_s.did,  b_s.sid,  b_s.chan}  = de[2][11:0];
    assign {ar_s.did, ar_s.sid, ar_s.chan} = de[3][23:0];
    assign {r_s.did,  r_s.sid,  r_s.chan}  = de[4][23:0];
    assign aw_s.valid = dv[0];
    assign w_s.valid  = dv[1];
    assign b_s.valid  = dv[2];
    assign ar_s.valid = dv[3];
    assign r_s.valid  = dv[4];
    assign aw_m.ready = dr[0];
    assign w_m.ready  = dr[1];
    assign b_m.ready  = dr[2];
    assign ar_m.ready = dr[3];
    assign r_m.ready  = dr[4];

    assign ie[0] = {8'h0, aw_s.did, aw_s.sid, aw_s.chan};
    assign ie[1] = {8'h0, w_s.did,  w_s.sid,  w_s.chan};
    assign ie[2] = {20'h0, b_s.did, b_s.sid,  b_s.chan};
    assign ie[3] = {8'h0, ar_s.did, ar_s.sid, ar_s.chan};
    assign ie[4] = {8'h0, r_s.did,  r_s.sid,  r_s.chan};
    assign oe[0] = {8'h0, aw_m.did, aw_m.sid, aw_m.chan};
    assign oe[1] = {8'h0, w_m.did,  w_m.sid,  w_m.chan};
    assign oe[2] = {20'h0, b_m.did, b_m.sid,  b_m.chan};
    assign oe[3] = {8'h0, ar_m.did, ar_m.sid, ar_m.chan};
    assign oe[4] = {8'h0, r_m.did,  r_m.sid,  r_m.chan};
    assign iv = '{aw_s.valid, w_s.valid, b_s.valid, ar_s.valid, r_s.valid};
    assign ir = '{aw_s.ready, w_s.ready, b_s.ready, ar_s.ready, r_s.ready};
    assign ov = '{aw_m.valid, w_m.valid, b_m.valid, ar_m.valid, r_m.valid};
    assign orr = '{aw_m.ready, w_m.ready, b_m.ready, ar_m.ready, r_m.ready};

    axi_grid_xni_buf #(
        .grid_id_t(id_def_t), .grid_aw_chan_t(aw_def_t),
        .grid_w_chan_t(w_def_t), .grid_b_chan_t(b_def_t),
        .grid_ar_chan_t(ar_def_t), .grid_r_chan_t(r_def_t),
        .NI_ID(4'd7), .AW_DEPTH(4), .W_DEPTH(2), .B_DEPTH(1),
        .AR_DEPTH(0), .R_DEPTH(3)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .aw_s(aw_s), .aw_m(aw_m), .w_s(w_s), .w_m(w_m),
        .b_s(b_s), .b_m(b_m), .ar_s(ar_s), .ar_m(ar_m),
        .r_s(r_s), .r_m(r_m),
        .aw_occ_o(occ[0]), .aw_hwm_o(hwm[0]),
        .w_occ_o(occ[1]),  .w_hwm_o(hwm[1]),
        .b_occ_o(occ[2]),  .b_hwm_o(hwm[2]),
        .ar_occ_o(occ[3]), .ar_hwm_o(hwm[3]),
        .r_occ_o(occ[4]),  .r_hwm_o(hwm[4])
    );

    int n_chk = 0;
    int n_pass = 0;
    int push_cnt [NUM_CHAN] = '{0, 0, 0, 0, 0};
    int pop_cnt  [NUM_CHAN] = '{0, 0, 0, 0, 0};
    logic [31:0] sbq [NUM_CHAN][$];
    logic bound_bad = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // accepted pushes enter the scoreboard; pops are checked in order
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (iv[c] && ir[c]) begin
                    sbq[c].push_back(ie[c]);
                    push_cnt[c]++;
                end
                if (ov[c] && orr[c]) begin
                    pop_cnt[c]++;
                    if (sbq[c].size() == 0)
                        chk($sformatf("extra_ch%0d", c), sbq[c].size(), 1);
                    else
                        chk($sformatf("order_ch%0d", c), oe[c], sbq[c].pop_front());
                end
                if (int'(occ[c]) > DEP[c] || int'(hwm[c]) > DEP[c]) bound_bad = 1'b1;
            end
            if (flush_i)
                for (int c = 0; c < NUM_CHAN; c++) sbq[c].delete();
        end
    end

    int fc [4] = '{0, 1, 2, 4};
    int b_push [NUM_CHAN];
    int b_pop [NUM_CHAN];
    int base;
    int cyc;
    bit done;

    initial begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            de[c] = 32'h00ABCDEF;
            dv[c] = 1'b1;
            dr[c] = 1'b0;
        end
        tick(4);
        foreach (fc[j]) begin
            chk($sformatf("rst_valid_ch%0d", fc[j]), ov[fc[j]], 0);
            chk($sformatf("rst_occ_ch%0d", fc[j]), occ[fc[j]], 0);
            chk($sformatf("rst_hwm_ch%0d", fc[j]), hwm[fc[j]], 0);
            chk($sformatf("rst_ready_ch%0d", fc[j]), ir[fc[j]], 0);
        end
        rst_ni = 1'b1;
        for (int c = 0; c < NUM_CHAN; c++) dv[c] = 1'b0;
        tick();
        foreach (fc[j]) begin
            chk($sformatf("rel_ready_ch%0d", fc[j]), ir[fc[j]], 1);
            chk($sformatf("rel_valid_ch%0d", fc[j]), ov[fc[j]], 0);
        end

        // AW depth 4 back-pressure then drain
        dr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            de[0] = {8'h0, 4'd3, 4'd1, 16'(k + 16'h100)};
            dv[0] = 1'b1;
            if (k < 4) begin
                chk("aw_ready_fill", ir[0], 1);
                tick();
            end
        end
        chk("aw_backpressure", ir[0], 0);
        chk("aw_occ_full", occ[0], 4);
        chk("aw_hwm_full", hwm[0], 4);
        tick();
        base = pop_cnt[0];
        dv[0] = 1'b0;
        dr[0] = 1'b1;
        tick(5);
        chk("aw_pops", pop_cnt[0] - base, 4);
        chk("aw_occ_empty", occ[0], 0);
        chk("aw_hwm_sticky", hwm[0], 4);

        // W depth 2 full throughput
        b_push[1] = push_cnt[1];
        b_pop[1] = pop_cnt[1];
        dr[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            de[1] = {8'h0, 4'd2, 4'd5, 16'(k)};
            dv[1] = 1'b1;
            tick();
        end
        dv[1] = 1'b0;
        tick();
        chk("w_pushes", push_cnt[1] - b_push[1], 100);
        chk("w_pops_1pc", pop_cnt[1] - b_pop[1], 100);

        // R depth 3 flush with a simultaneous offer
        dr[4] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            de[4] = {8'h0, 4'd4, 4'd6, 16'(k + 16'h40)};
            dv[4] = 1'b1;
            tick();
        end
        dv[4] = 1'b0;
        chk("r_occ_full", occ[4], 3);
        de[4] = 32'h00_99_BEEF;
        dv[4] = 1'b1;
        dr[4] = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("r_flush_ready", ir[4], 0);
        tick();
        flush_i = 1'b0;
        dv[4] = 1'b0;
        chk("r_flush_occ", occ[4], 0);
        chk("r_flush_hwm", hwm[4], 0);
        chk("r_flush_valid", ov[4], 0);
        chk("aw_flush_hwm", hwm[0], 0);
        base = pop_cnt[4];
        tick(4);
        chk("r_flush_nopop", pop_cnt[4] - base, 0);

        // B depth 1 alternating ready
        base = pop_cnt[2];
        dr[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            de[2] = 32'(i * 3);
            dv[2] = 1'b1;
            chk($sformatf("b_ready_c%0d", i), ir[2], 32'((i % 2) == 0));
            tick();
        end
        dv[2] = 1'b0;
        chk("b_pops_half", pop_cnt[2] - base, 5);

        // AR depth 0 pass-through
        for (int i = 0; i < 4; i++) begin
            de[3] = $urandom;
            dv[3] = i[0];
            dr[3] = i[1];
            #1;
            chk("ar_data", oe[3], {8'h0, de[3][23:0]});
            chk("ar_valid", ov[3], dv[3]);
            chk("ar_ready", ir[3], dr[3]);
            chk("ar_occ", occ[3], 0);
            tick();
        end
        dv[3] = 1'b0;

        // random traffic on all channels
        for (int c = 0; c < NUM_CHAN; c++) begin
            b_push[c] = push_cnt[c];
            b_pop[c] = pop_cnt[c];
        end
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 60000) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                dv[c] = (push_cnt[c] - b_push[c] < N_RND) ? 1'($urandom_range(0, 1)) : 1'b0;
                de[c] = $urandom;
                dr[c] = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            done = 1'b1;
            for (int c = 0; c < NUM_CHAN; c++)
                if (push_cnt[c] - b_push[c] < N_RND) done = 1'b0;
        end
        chk("rnd_within_budget", 32'(done), 1);
        for (int c = 0; c < NUM_CHAN; c++) begin
            dv[c] = 1'b0;
            dr[c] = 1'b1;
        end
        tick(10);
        for (int c = 0; c < NUM_CHAN; c++) begin
            chk($sformatf("rnd_push_ch%0d", c), push_cnt[c] - b_push[c], N_RND);
            chk($sformatf("rnd_pop_ch%0d", c), pop_cnt[c] - b_pop[c], N_RND);
            chk($sformatf("rnd_left_ch%0d", c), sbq[c].size(), 0);
            chk($sformatf("rnd_occ0_ch%0d", c), occ[c], 0);
        end
        chk("occ_hwm_bound", 32'(bound_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
